control_pipeline: RTL and testbench

Receiving end of the control decoder's outputs: captures the ID-stage control word and carries it through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32I pipeline. Detects load-use hazards and generates stall/bubble. Generates branch/jump redirect flushes. Produces EX-stage forwarding selects for ALU operands A and B.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/hazard_unit.sv | 59 +++++
 rtl/control_pipeline.sv | 134 +++++++++++++
 tb/tb_control_pipeline.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control-path types for the RV32I pipeline control slice.
package cpu_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 3;

  // Next-PC source chosen by the decoder
  typedef enum logic [1:0] {
    PC4    = 2'b00,
    BRANCH = 2'b01,
    JAL    = 2'b10,
    JALR   = 2'b11
  } next_pc_sel_e;

  // EX operand source
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } forward_sel_e;

  // Control word carried through ID/EX, EX/MEM and MEM/WB
  typedef struct packed {
    logic                valid;
    logic                write;
    logic                store;
    logic                load;
    logic                branch;
    logic [1:0]          a_sel;
    logic                b_sel;
    logic [ALU_OP_W-1:0] alu_op;
    next_pc_sel_e        next_pc_sel;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall, EX redirect and operand forwarding.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic             ex_branch,
  input  next_pc_sel_e     ex_next_pc_sel,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_valid,
  input  logic             mem_write,
  input  logic             mem_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             branch_taken,
  output logic             stall_c,
  output logic             redirect_c,
  output forward_sel_e     forward_a_c,
  output forward_sel_e     forward_b_c
);

  logic mem_fwd_ok;
  logic wb_fwd_ok;
  logic load_use;
  logic jump;

  // Forwarding source for one EX operand; MEM beats WB, loads never leave MEM early
  function automatic forward_sel_e pick(input logic [REG_W-1:0] rs);
    forward_sel_e sel;
    sel = FWD_RF;
    if (mem_fwd_ok && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Redirect, load-use stall and forwarding selects
  always_comb begin
    jump        = (ex_next_pc_sel == JAL) || (ex_next_pc_sel == JALR);
    redirect_c  = ex_valid & ((ex_branch & branch_taken) | jump);
    load_use    = ex_valid & ex_load & (ex_rd != '0) & id_valid &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    stall_c     = load_use & ~redirect_c;
    mem_fwd_ok  = mem_valid & mem_write & ~mem_load & (mem_rd != '0);
    wb_fwd_ok   = wb_valid & wb_write & (wb_rd != '0);
    forward_a_c = pick(ex_rs1);
    forward_b_c = pick(ex_rs2);
  end

endmodule

// File: rtl/control_pipeline.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with hazard handling.
module control_pipeline
  import cpu_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_W,
  parameter int unsigned ALU_OP_WIDTH   = ALU_OP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  input  logic                      id_write_i,
  input  logic                      id_store_i,
  input  logic                      id_load_i,
  input  logic                      id_branch_i,
  input  logic [1:0]                id_alu_operand_a_selector_i,
  input  logic                      id_alu_operand_b_selector_i,
  input  logic [1:0]                id_next_pc_selector_i,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_operations_selector_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic                      branch_taken_i,
  output logic                      stall_o,
  output logic                      flush_o,
  output logic                      redirect_o,
  output logic                      ex_valid_o,
  output logic [1:0]                ex_alu_operand_a_selector_o,
  output logic                      ex_alu_operand_b_selector_o,
  output logic [ALU_OP_WIDTH-1:0]   ex_alu_operations_selector_o,
  output logic [1:0]                ex_next_pc_selector_o,
  output logic [1:0]                forward_a_o,
  output logic [1:0]                forward_b_o,
  output logic                      mem_valid_o,
  output logic                      mem_store_o,
  output logic                      mem_load_o,
  output logic                      wb_valid_o,
  output logic                      wb_write_o,
  output logic                      wb_load_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o
);

  ctrl_word_t   id_word;
  ctrl_word_t   ex_d;
  ctrl_word_t   ex_q;
  ctrl_word_t   mem_q;
  ctrl_word_t   wb_q;
  logic         stall;
  logic         redirect;
  forward_sel_e fwd_a;
  forward_sel_e fwd_b;
  logic         unused_wb;

  // Pack decoder outputs into a control word; bubble it on stall or redirect
  always_comb begin
    id_word             = BUBBLE;
    id_word.valid       = id_valid_i;
    id_word.write       = id_write_i;
    id_word.store       = id_store_i;
    id_word.load        = id_load_i;
    id_word.branch      = id_branch_i;
    id_word.a_sel       = id_alu_operand_a_selector_i;
    id_word.b_sel       = id_alu_operand_b_selector_i;
    id_word.alu_op      = ALU_OP_W'(id_alu_operations_selector_i);
    id_word.next_pc_sel = next_pc_sel_e'(id_next_pc_selector_i);
    id_word.rs1         = REG_W'(id_rs1_i);
    id_word.rs2         = REG_W'(id_rs2_i);
    id_word.rd          = REG_W'(id_rd_i);
    ex_d                = (stall || redirect) ? BUBBLE : id_word;
  end

  // Stage registers advance every cycle; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  hazard_unit u_hazard (
    .ex_valid       (ex_q.valid),
    .ex_load        (ex_q.load),
    .ex_branch      (ex_q.branch),
    .ex_next_pc_sel (ex_q.next_pc_sel),
    .ex_rs1         (ex_q.rs1),
    .ex_rs2         (ex_q.rs2),
    .ex_rd          (ex_q.rd),
    .mem_valid      (mem_q.valid),
    .mem_write      (mem_q.write),
    .mem_load       (mem_q.load),
    .mem_rd         (mem_q.rd),
    .wb_valid       (wb_q.valid),
    .wb_write       (wb_q.write),
    .wb_rd          (wb_q.rd),
    .id_valid       (id_valid_i),
    .id_rs1         (REG_W'(id_rs1_i)),
    .id_rs2         (REG_W'(id_rs2_i)),
    .branch_taken   (branch_taken_i),
    .stall_c        (stall),
    .redirect_c     (redirect),
    .forward_a_c    (fwd_a),
    .forward_b_c    (fwd_b)
  );

  // Hazard outputs
  assign stall_o     = stall;
  assign redirect_o  = redirect;
  assign flush_o     = redirect;
  assign forward_a_o = 2'(fwd_a);
  assign forward_b_o = 2'(fwd_b);

  // Stage controls, each qualified by its stage valid
  assign ex_valid_o                   = ex_q.valid;
  assign ex_alu_operand_a_selector_o  = ex_q.a_sel & {2{ex_q.valid}};
  assign ex_alu_operand_b_selector_o  = ex_q.b_sel & ex_q.valid;
  assign ex_alu_operations_selector_o = ALU_OP_WIDTH'(ex_q.alu_op & {ALU_OP_W{ex_q.valid}});
  assign ex_next_pc_selector_o        = 2'(ex_q.next_pc_sel) & {2{ex_q.valid}};
  assign mem_valid_o                  = mem_q.valid;
  assign mem_store_o                  = mem_q.store & mem_q.valid;
  assign mem_load_o                   = mem_q.load & mem_q.valid;
  assign wb_valid_o                   = wb_q.valid;
  assign wb_write_o                   = wb_q.write & wb_q.valid & (wb_q.rd != '0);
  assign wb_load_o                    = wb_q.load & wb_q.valid;
  assign wb_rd_o                      = REG_ADDR_WIDTH'(wb_q.rd & {REG_W{wb_q.valid}});

  // Fields that have no consumer past writeback
  assign unused_wb = ^{wb_q.store, wb_q.branch, wb_q.a_sel, wb_q.b_sel,
                       wb_q.alu_op, wb_q.next_pc_sel, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_control_pipeline.sv
// Directed table-driven bench for control_pipeline.
module tb_control_pipeline;

  typedef struct packed {
    logic       valid, write, store, load, branch;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [2:0] alu_op;
    logic [1:0] npc;
    logic [4:0] rs1, rs2, rd;
  } id_in_t;

  typedef struct packed {
    logic       stall, flush, redirect, ex_valid;
    logic [1:0] ex_a_sel;
    logic       ex_b_sel;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_npc;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_valid, mem_store, mem_load;
    logic       wb_valid, wb_write, wb_load;
    logic [4:0] wb_rd;
  } obs_t;

  typedef struct packed {
    id_in_t id;
    logic   taken;
    obs_t   exp;
  } vec_t;

  logic       clk, rst_n, branch_taken;
  id_in_t     id;
  logic       stall, flush, redirect, ex_valid, ex_b_sel;
  logic [1:0] ex_a_sel, ex_npc, fwd_a, fwd_b;
  logic [2:0] ex_alu_op;
  logic       mem_valid, mem_store, mem_load, wb_valid, wb_write, wb_load;
  logic [4:0] wb_rd;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs [16];

  control_pipeline dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .id_valid_i                   (id.valid),
    .id_write_i                   (id.write),
    .id_store_i                   (id.store),
    .id_load_i                    (id.load),
    .id_branch_i                  (id.branch),
    .id_alu_operand_a_selector_i  (id.a_sel),
    .id_alu_operand_b_selector_i  (id.b_sel),
    .id_next_pc_selector_i        (id.npc),
    .id_alu_operations_selector_i (id.alu_op),
    .id_rs1_i                     (id.rs1),
    .id_rs2_i                     (id.rs2),
    .id_rd_i                      (id.rd),
    .branch_taken_i               (branch_taken),
    .stall_o                      (stall),
    .flush_o                      (flush),
    .redirect_o                   (redirect),
    .ex_valid_o                   (ex_valid),
    .ex_alu_operand_a_selector_o  (ex_a_sel),
    .ex_alu_operand_b_selector_o  (ex_b_sel),
    .ex_alu_operations_selector_o (ex_alu_op),
    .ex_next_pc_selector_o        (ex_npc),
    .forward_a_o                  (fwd_a),
    .forward_b_o                  (fwd_b),
    .mem_valid_o                  (mem_valid),
    .mem_store_o                  (mem_store),
    .mem_load_o                   (mem_load),
    .wb_valid_o                   (wb_valid),
    .wb_write_o                   (wb_write),
    .wb_load_o                    (wb_load),
    .wb_rd_o                      (wb_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction builders
  function automatic id_in_t nop();
    return '0;
  endfunction

  function automatic id_in_t add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_in_t i = '0;
    i.valid = 1'b1; i.write = 1'b1; i.alu_op = 3'd2;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic id_in_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    id_in_t i = '0;
    i.valid = 1'b1; i.write = 1'b1; i.load = 1'b1; i.b_sel = 1'b1; i.alu_op = 3'd1;
    i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic id_in_t br(input logic [4:0] rs1, input logic [4:0] rs2);
    id_in_t i = '0;
    i.valid = 1'b1; i.branch = 1'b1; i.npc = 2'b01; i.alu_op = 3'd5;
    i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  // Load-flavoured JALR: exercises redirect and load-use together
  function automatic id_in_t lj(input logic [4:0] rd, input logic [4:0] rs1);
    id_in_t i = '0;
    i.valid = 1'b1; i.write = 1'b1; i.load = 1'b1; i.a_sel = 2'd2; i.npc = 2'b11;
    i.alu_op = 3'd6; i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic obs_t eo(
    input logic st, input logic rd_, input logic exv, input logic [1:0] asel,
    input logic bsel, input logic [2:0] alu, input logic [1:0] npc,
    input logic [1:0] fa, input logic [1:0] fb, input logic memv, input logic mems,
    input logic meml, input logic wbv, input logic wbw, input logic wbl,
    input logic [4:0] wbrd);
    obs_t o;
    o.stall = st; o.flush = rd_; o.redirect = rd_; o.ex_valid = exv;
    o.ex_a_sel = asel; o.ex_b_sel = bsel; o.ex_alu_op = alu; o.ex_npc = npc;
    o.fwd_a = fa; o.fwd_b = fb;
    o.mem_valid = memv; o.mem_store = mems; o.mem_load = meml;
    o.wb_valid = wbv; o.wb_write = wbw; o.wb_load = wbl; o.wb_rd = wbrd;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.stall = stall; o.flush = flush; o.redirect = redirect; o.ex_valid = ex_valid;
    o.ex_a_sel = ex_a_sel; o.ex_b_sel = ex_b_sel; o.ex_alu_op = ex_alu_op; o.ex_npc = ex_npc;
    o.fwd_a = fwd_a; o.fwd_b = fwd_b;
    o.mem_valid = mem_valid; o.mem_store = mem_store; o.mem_load = mem_load;
    o.wb_valid = wb_valid; o.wb_write = wb_write; o.wb_load = wb_load; o.wb_rd = wb_rd;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table: one row per cycle, expectations hand-derived
    vecs[0]  = '{add(5, 1, 2),   1'b0, eo(0,0, 0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0)};
    vecs[1]  = '{add(6, 5, 3),   1'b0, eo(0,0, 1,0,0,2,0, 0,0, 0,0,0, 0,0,0,0)};
    vecs[2]  = '{add(11, 5, 6),  1'b0, eo(0,0, 1,0,0,2,0, 1,0, 1,0,0, 0,0,0,0)};
    vecs[3]  = '{add(0, 9, 9),   1'b0, eo(0,0, 1,0,0,2,0, 2,1, 1,0,0, 1,1,0,5)};
    vecs[4]  = '{add(12, 0, 11), 1'b0, eo(0,0, 1,0,0,2,0, 0,0, 1,0,0, 1,1,0,6)};
    vecs[5]  = '{lw(7, 1),       1'b0, eo(0,0, 1,0,0,2,0, 0,2, 1,0,0, 1,1,0,11)};
    vecs[6]  = '{add(13, 2, 7),  1'b0, eo(1,0, 1,0,1,1,0, 0,0, 1,0,0, 1,0,0,0)};
    vecs[7]  = '{add(13, 2, 7),  1'b0, eo(0,0, 0,0,0,0,0, 0,0, 1,0,1, 1,1,0,12)};
    vecs[8]  = '{br(1, 2),       1'b0, eo(0,0, 1,0,0,2,0, 0,2, 0,0,0, 1,1,1,7)};
    vecs[9]  = '{br(3, 4),       1'b0, eo(0,0, 1,0,0,5,1, 0,0, 1,0,0, 0,0,0,0)};
    vecs[10] = '{add(15, 1, 1),  1'b1, eo(0,1, 1,0,0,5,1, 0,0, 1,0,0, 1,1,0,13)};
    vecs[11] = '{lj(7, 1),       1'b0, eo(0,0, 0,0,0,0,0, 0,0, 1,0,0, 1,0,0,0)};
    vecs[12] = '{add(16, 7, 2),  1'b0, eo(0,1, 1,2,0,6,3, 0,0, 0,0,0, 1,0,0,0)};
    vecs[13] = '{nop(),          1'b0, eo(0,0, 0,0,0,0,0, 0,0, 1,0,1, 0,0,0,0)};
    vecs[14] = '{nop(),          1'b0, eo(0,0, 0,0,0,0,0, 0,0, 0,0,0, 1,1,1,7)};
    vecs[15] = '{nop(),          1'b0, eo(0,0, 0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0)};

    // Reset held with a valid instruction at the input
    rst_n = 1'b0;
    branch_taken = 1'b0;
    id = add(5, 1, 2);
    @(negedge clk);
    check("reset_hold", 32'(sample()), 32'(obs_t'('0)));
    #1 rst_n = 1'b1;
    next_cycle();
    id = nop();
    @(negedge clk);
    check("post_reset_ex", 32'(sample()), 32'(eo(0,0, 1,0,0,2,0, 0,0, 0,0,0, 0,0,0,0)));
    next_cycle();
    @(negedge clk);
    check("post_reset_mem", 32'(sample()), 32'(eo(0,0, 0,0,0,0,0, 0,0, 1,0,0, 0,0,0,0)));
    next_cycle();
    @(negedge clk);
    check("post_reset_wb", 32'(sample()), 32'(eo(0,0, 0,0,0,0,0, 0,0, 0,0,0, 1,1,0,5)));

    // Clean start for the table
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      id = vecs[i].id;
      branch_taken = vecs[i].taken;
      @(negedge clk);
      check($sformatf("row%0d", i), 32'(sample()), 32'(vecs[i].exp));
      next_cycle();
    end

    // Three instructions in flight, then asynchronous reset mid-cycle
    branch_taken = 1'b0;
    id = add(20, 1, 2);
    next_cycle();
    id = add(21, 3, 4);
    next_cycle();
    id = add(22, 8, 9);
    next_cycle();
    id = nop();
    #1;
    check("inflight_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'(3'b111));
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 32'({ex_valid, mem_valid, wb_valid, wb_write, wb_rd}), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("after_async_release", 32'(sample()), 32'(obs_t'('0)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
